// File: rtl/blk_duty_calc.sv
// Per-block peak-luma tracker: accumulates max(R,G,B) per horizontal block and,
// on each row strobe, drains the row's maxima serially as backlight duty values.
module blk_duty_calc #(
    parameter int unsigned  LANES    = 8,
    parameter int unsigned  NBLK     = 8,
    parameter logic [7:0]   MIN_DUTY = 8'd16,
    localparam int unsigned BW       = $clog2(NBLK),
    localparam int unsigned AW       = BW + 4
) (
    input  logic                  iODCK,
    input  logic                  iRST_n,
    input  logic [24*LANES-1:0]   iPixelData,
    input  logic                  iPixVld,
    input  logic [BW-1:0]         iBlkIdx,
    input  logic [3:0]            iV_Address,
    input  logic                  iV_Duty,
    input  logic                  iALG_rst,
    input  logic                  iOU_en,
    output logic [7:0]            oDuty,
    output logic [AW-1:0]         oDutyAddr,
    output logic                  oDutyVld,
    output logic                  oBusy,
    output logic                  oOvf
);

    typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [7:0]    s1Max [LANES];
    logic          s1Vld, d1Duty;
    logic [BW-1:0] s1Blk;
    logic [3:0]    d1Addr;

    logic [7:0]    laneMax;
    logic [7:0]    s2Max;
    logic          s2Vld, d2Duty;
    logic [BW-1:0] s2Blk;
    logic [3:0]    d2Addr;

    logic [7:0]    acc     [NBLK];
    logic [7:0]    accUpd  [NBLK];
    logic [7:0]    shadow  [NBLK];
    logic [3:0]    shadowRow;
    logic          rowTake;

    state_t        state, stateNxt;
    logic [BW-1:0] cnt, cntNxt;
    logic [7:0]    dutyNxt;
    logic [AW-1:0] addrNxt;
    logic          vldNxt, ovfNxt;

    // Stage 1: per-lane peak of R, G, B
    always_ff @(posedge iODCK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int k = 0; k < int'(LANES); k++) s1Max[k] <= '0;
            s1Vld  <= 1'b0;
            s1Blk  <= '0;
            d1Duty <= 1'b0;
            d1Addr <= '0;
        end else begin
            for (int k = 0; k < int'(LANES); k++)
                s1Max[k] <= max8(max8(iPixelData[24*k+16 +: 8], iPixelData[24*k+8 +: 8]),
                                 iPixelData[24*k +: 8]);
            s1Vld  <= iPixVld && !iALG_rst;
            s1Blk  <= iBlkIdx;
            d1Duty <= iV_Duty && !iALG_rst;
            d1Addr <= iV_Address;
        end
    end

    always_comb begin
        laneMax = '0;
        for (int k = 0; k < int'(LANES); k++) laneMax = max8(laneMax, s1Max[k]);
    end

    // Stage 2: peak across lanes, strobe/address kept aligned
    always_ff @(posedge iODCK or negedge iRST_n) begin
        if (!iRST_n) begin
            s2Max  <= '0;
            s2Vld  <= 1'b0;
            s2Blk  <= '0;
            d2Duty <= 1'b0;
            d2Addr <= '0;
        end else begin
            s2Max  <= laneMax;
            s2Vld  <= s1Vld && !iALG_rst;
            s2Blk  <= s1Blk;
            d2Duty <= d1Duty && !iALG_rst;
            d2Addr <= d1Addr;
        end
    end

    // Accumulator values including this cycle's S2 word, so a snapshot sees it
    always_comb begin
        for (int i = 0; i < int'(NBLK); i++) begin
            accUpd[i] = acc[i];
            if (s2Vld && (s2Blk == BW'(i))) accUpd[i] = max8(acc[i], s2Max);
        end
    end

    assign rowTake = d2Duty && (state == ACCUM);

    always_ff @(posedge iODCK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < int'(NBLK); i++) begin
                acc[i]    <= '0;
                shadow[i] <= '0;
            end
            shadowRow <= '0;
        end else if (iALG_rst) begin
            for (int i = 0; i < int'(NBLK); i++) acc[i] <= '0;
        end else if (rowTake) begin
            for (int i = 0; i < int'(NBLK); i++) begin
                shadow[i] <= accUpd[i];
                acc[i]    <= '0;
            end
            shadowRow <= d2Addr;
        end else begin
            for (int i = 0; i < int'(NBLK); i++) acc[i] <= accUpd[i];
        end
    end

    // Drain sequencer: next state and next registered outputs
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        vldNxt   = 1'b0;
        dutyNxt  = oDuty;
        addrNxt  = oDutyAddr;
        ovfNxt   = oOvf;
        if (iALG_rst) begin
            stateNxt = ACCUM;
            cntNxt   = '0;
            ovfNxt   = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (d2Duty) begin
                        stateNxt = DRAIN;
                        cntNxt   = '0;
                    end
                end
                DRAIN: begin
                    if (d2Duty) ovfNxt = 1'b1;
                    if (iOU_en) begin
                        vldNxt  = 1'b1;
                        dutyNxt = max8(shadow[cnt], MIN_DUTY);
                        addrNxt = {shadowRow, cnt};
                        cntNxt  = cnt + BW'(1);
                        if (cnt == BW'(NBLK - 1)) stateNxt = ACCUM;
                    end
                end
                default: stateNxt = ACCUM;
            endcase
        end
    end

    always_ff @(posedge iODCK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= ACCUM;
            cnt       <= '0;
            oDuty     <= '0;
            oDutyAddr <= '0;
            oDutyVld  <= 1'b0;
            oBusy     <= 1'b0;
            oOvf      <= 1'b0;
        end else begin
            state     <= stateNxt;
            cnt       <= cntNxt;
            oDuty     <= dutyNxt;
            oDutyAddr <= addrNxt;
            oDutyVld  <= vldNxt;
            oBusy     <= (stateNxt == DRAIN);
            oOvf      <= ovfNxt;
        end
    end

endmodule
